// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// This block merges the pipeline writeback stream and the load-return stream
// onto the register file's single write port. It also keeps a scoreboard of
// registers that have loads outstanding. It raises one stall request for
// read-after-load, write-after-load and double-issue hazards, and for the cycle
// in which a starved load return takes the write port away from writeback.
module rf_wb_arbiter #(
   parameter int REG_NUM      = 32,
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_valid,
   input  logic [ADDR_W-1:0]  wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               ld_valid,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   output logic               ld_ready,
   input  logic               iss_ld,
   input  logic [ADDR_W-1:0]  iss_addr,
   input  logic               re1,
   input  logic               re2,
   input  logic [ADDR_W-1:0]  raddr1,
   input  logic [ADDR_W-1:0]  raddr2,
   output logic               rf_we,
   output logic [ADDR_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic               stall_req,
   output logic [REG_NUM-1:0] pending,
   output logic [CNT_W-1:0]   starve_cnt
);

   // State: the scoreboard and the refusal counter.
   logic [REG_NUM-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

   // One-hot decodes of each address. Bit 0 is held at zero, so x0 can never
   // hit the scoreboard. That single choice covers every "addr != 0" term.
   logic [REG_NUM-1:0] rd1_oh, rd2_oh, wb_oh, iss_oh, ld_oh;

   // Combinational arbitration terms.
   logic rd_haz, waw_haz, iss_haz, starve_win;
   logic ld_fire, wb_grant;
   logic [REG_NUM-1:0] set_vec, clr_vec;

   assign rd1_oh[0] = 1'b0;
   assign rd2_oh[0] = 1'b0;
   assign wb_oh[0]  = 1'b0;
   assign iss_oh[0] = 1'b0;
   assign ld_oh[0]  = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < REG_NUM; gi++) begin : g_dec
         assign rd1_oh[gi] = (raddr1   == ADDR_W'(gi));
         assign rd2_oh[gi] = (raddr2   == ADDR_W'(gi));
         assign wb_oh[gi]  = (wb_addr  == ADDR_W'(gi));
         assign iss_oh[gi] = (iss_addr == ADDR_W'(gi));
         assign ld_oh[gi]  = (ld_addr  == ADDR_W'(gi));
      end
   endgenerate

   // Hazard detection. It looks only at the registered scoreboard, so there is
   // no same-cycle bypass.
   always_comb begin
      rd_haz     = (re1 & (|(pending_q & rd1_oh))) |
                   (re2 & (|(pending_q & rd2_oh)));
      waw_haz    = wb_valid & (|(pending_q & wb_oh));
      iss_haz    = iss_ld & (|(pending_q & iss_oh));
      starve_win = ld_valid & wb_valid &
                   (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   end

   // Handshakes. Reset forces stall, load acceptance and writeback grant low.
   always_comb begin
      stall_req = ~rst & (rd_haz | waw_haz | iss_haz | starve_win);
      ld_ready  = ~rst & (~wb_valid | stall_req);
      ld_fire   = ld_valid & ld_ready;
      wb_grant  = ~rst & wb_valid & ~stall_req;
   end

   // Write-port mux: a firing load has priority, then writeback. When idle the
   // address and data are driven to zero. Writes to x0 are dropped.
   always_comb begin
      rf_waddr = '0;
      rf_wdata = '0;
      if (ld_fire) begin
         rf_waddr = ld_addr;
         rf_wdata = ld_data;
      end else if (wb_grant) begin
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end
      rf_we = (ld_fire | wb_grant) & (rf_waddr != '0);
   end

   // Scoreboard next state. A returning load clears its bit and an accepted
   // issue sets its bit. iss_haz stops both from hitting the same bit.
   always_comb begin
      clr_vec   = ld_oh  & {REG_NUM{ld_fire}};
      set_vec   = iss_oh & {REG_NUM{iss_ld & ~stall_req}};
      pending_d = (pending_q & ~clr_vec) | set_vec;
      if (rst) begin
         pending_d = '0;
      end
   end

   // Refusal counter next state. It counts consecutive cycles in which a valid
   // load is refused and saturates at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (rst || ld_fire || !ld_valid) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      pending_q    <= pending_d;
      starve_cnt_q <= starve_cnt_d;
   end

   assign pending    = pending_q;
   assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter. It runs the directed scenarios first, then a
// randomized phase. A scoreboard model built from the arbitration rules
// supplies the expected value at every step.
module tb_rf_wb_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ld_valid;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        iss_ld;
   logic [4:0]  iss_addr;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic [31:0] pending;
   logic [2:0]  starve_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] m_pend;
   int          m_cnt;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .REG_NUM(32), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ready(ld_ready),
      .iss_ld(iss_ld), .iss_addr(iss_addr),
      .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall_req(stall_req), .pending(pending), .starve_cnt(starve_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      wb_valid = 0; wb_addr = 0; wb_data = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      iss_ld = 0; iss_addr = 0;
      re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
   endtask

   // Checks one clock cycle against the model. It settles the current inputs,
   // compares the combinational outputs, crosses the edge, and then compares
   // the state.
   task automatic step(input string tag);
      logic        e_stall, e_ldr, e_fire, e_grant, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd, np;
      int          nc;
      #2;
      if (rst) begin
         e_stall = 0; e_ldr = 0; e_fire = 0; e_grant = 0; e_we = 0;
         e_wa = 0; e_wd = 0;
         np = 0; nc = 0;
      end else begin
         e_stall = (re1 && raddr1 != 0 && m_pend[raddr1]) ||
                   (re2 && raddr2 != 0 && m_pend[raddr2]) ||
                   (wb_valid && wb_addr != 0 && m_pend[wb_addr]) ||
                   (iss_ld && iss_addr != 0 && m_pend[iss_addr]) ||
                   (ld_valid && wb_valid && m_cnt == LIMIT);
         e_ldr   = !wb_valid || e_stall;
         e_fire  = ld_valid && e_ldr;
         e_grant = wb_valid && !e_stall;
         if (e_fire) begin
            e_wa = ld_addr; e_wd = ld_data;
         end else if (e_grant) begin
            e_wa = wb_addr; e_wd = wb_data;
         end else begin
            e_wa = 0; e_wd = 0;
         end
         e_we = (e_fire || e_grant) && e_wa != 0;
         np = m_pend;
         if (e_fire && ld_addr != 0) np[ld_addr] = 1'b0;
         if (iss_ld && !e_stall && iss_addr != 0) np[iss_addr] = 1'b1;
         nc = (e_fire || !ld_valid) ? 0 : ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1);
      end
      check({tag, ".stall_req"}, 64'(stall_req), 64'(e_stall));
      check({tag, ".ld_ready"},  64'(ld_ready),  64'(e_ldr));
      check({tag, ".rf_we"},     64'(rf_we),     64'(e_we));
      if (!rst) begin
         check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(e_wa));
         check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(e_wd));
      end
      @(posedge clk);
      #1;
      m_pend = np;
      m_cnt  = nc;
      check({tag, ".pending"},    64'(pending),    64'(m_pend));
      check({tag, ".starve_cnt"}, 64'(starve_cnt), 64'(m_cnt));
      $display("step %s: stall=%0b ld_ready=%0b we=%0b waddr=%0d pending=%08h cnt=%0d",
               tag, e_stall, e_ldr, e_we, e_wa, m_pend, m_cnt);
   endtask

   initial begin
      m_pend = 0;
      m_cnt  = 0;
      idle_inputs();

      // Reset held for two cycles, with an issue and both requests active.
      rst = 1; iss_ld = 1; iss_addr = 5; wb_valid = 1; wb_addr = 2; ld_valid = 1; ld_addr = 3;
      step("rst0");
      step("rst1");
      check("rst.pending_zero", 64'(pending), 64'd0);
      check("rst.cnt_zero", 64'(starve_cnt), 64'd0);

      // Read-after-load on x5.
      rst = 0; idle_inputs();
      iss_ld = 1; iss_addr = 5;
      step("raw.issue");
      iss_ld = 0; re1 = 1; raddr1 = 5;
      #1 check("raw.stall", 64'(stall_req), 64'd1);
      step("raw.stalled");
      ld_valid = 1; ld_addr = 5; ld_data = 32'hDEADBEEF;
      #1 check("raw.ld_we", 64'(rf_we), 64'd1);
      check("raw.ld_waddr", 64'(rf_waddr), 64'd5);
      check("raw.ld_wdata", 64'(rf_wdata), 64'hDEADBEEF);
      step("raw.return");
      ld_valid = 0;
      #1 check("raw.unstall", 64'(stall_req), 64'd0);
      check("raw.pend5", 64'(pending[5]), 64'd0);
      step("raw.read");

      // Starvation: continuous writeback to x3 while a load to x7 waits.
      idle_inputs();
      wb_valid = 1; wb_addr = 3; wb_data = 32'h33;
      ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
      for (int i = 1; i <= LIMIT; i++) begin
         #1 check("starve.refused", 64'(ld_ready), 64'd0);
         step("starve.wait");
         check("starve.cnt", 64'(starve_cnt), 64'(i));
      end
      #1 check("starve.win_stall", 64'(stall_req), 64'd1);
      check("starve.win_waddr", 64'(rf_waddr), 64'd7);
      step("starve.win");
      check("starve.cnt_clr", 64'(starve_cnt), 64'd0);
      ld_valid = 0;
      #1 check("starve.wb_waddr", 64'(rf_waddr), 64'd3);
      check("starve.wb_we", 64'(rf_we), 64'd1);
      step("starve.wb");

      // Write-after-load on x9.
      idle_inputs();
      iss_ld = 1; iss_addr = 9;
      step("waw.issue");
      iss_ld = 0; wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
      #1 check("waw.stall", 64'(stall_req), 64'd1);
      check("waw.ld_ready", 64'(ld_ready), 64'd1);
      check("waw.no_we", 64'(rf_we), 64'd0);
      step("waw.hold");
      ld_valid = 1; ld_addr = 9; ld_data = 32'h1009;
      step("waw.ld");
      ld_valid = 0;
      #1 check("waw.wb_data", 64'(rf_wdata), 64'h99);
      step("waw.wb");

      // Double issue on x4.
      idle_inputs();
      iss_ld = 1; iss_addr = 4;
      step("dbl.issue");
      #1 check("dbl.stall", 64'(stall_req), 64'd1);
      step("dbl.reissue");
      check("dbl.pend_kept", 64'(pending[4]), 64'd1);
      ld_valid = 1; ld_addr = 4; ld_data = 32'h44;
      step("dbl.ld");
      ld_valid = 0;
      step("dbl.reissue_ok");
      check("dbl.pend_set", 64'(pending[4]), 64'd1);
      iss_ld = 0; ld_valid = 1; ld_addr = 4;
      step("dbl.drain");

      // x0 traffic.
      idle_inputs();
      wb_valid = 1; wb_addr = 0; wb_data = 32'h5;
      #1 check("x0.wb_we", 64'(rf_we), 64'd0);
      step("x0.wb");
      idle_inputs();
      ld_valid = 1; ld_addr = 0; ld_data = 32'h6;
      #1 check("x0.ld_ready", 64'(ld_ready), 64'd1);
      step("x0.ld");
      idle_inputs();
      iss_ld = 1; iss_addr = 0;
      step("x0.iss");
      check("x0.pend0", 64'(pending[0]), 64'd0);

      // Random traffic over a small address window, so that hazards are frequent.
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 59) == 0);
         wb_valid = $urandom_range(0, 1);
         wb_addr  = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         ld_valid = $urandom_range(0, 1);
         ld_addr  = 5'($urandom_range(0, 7));
         ld_data  = $urandom;
         iss_ld   = ($urandom_range(0, 2) == 0);
         iss_addr = 5'($urandom_range(0, 7));
         re1      = $urandom_range(0, 1);
         re2      = $urandom_range(0, 1);
         raddr1   = 5'($urandom_range(0, 7));
         raddr2   = 5'($urandom_range(0, 7));
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
